// File: rtl/led_trail_fader.sv
// Per-LED PWM driver that turns a one-hot scanner pattern into a fading comet tail.
// Lit LEDs load max_level; dark LEDs halve (or shift down) their level on each decay tick.
module led_trail_fader #(
  parameter int          PWM_BITS     = 8,
  parameter logic [21:0] DECAY_PERIOD = 22'd999999,
  parameter int          DECAY_SHIFT  = 1
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic [7:0]          led_in,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] max_level,
  output logic [7:0]          pwm_out
);

  // PWM counter stops one short of all-ones so a full-scale level is 100% on.
  localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [7:0]          led_q_reg;
  logic [21:0]         decay_cnt_reg, decay_cnt_next;
  logic [PWM_BITS-1:0] pwm_cnt_reg, pwm_cnt_next;
  logic                tick;

  always_comb begin
    decay_cnt_next = '0;
    pwm_cnt_next   = '0;
    if (enable) begin
      if (decay_cnt_reg != DECAY_PERIOD)
        decay_cnt_next = decay_cnt_reg + 22'd1;
      if (pwm_cnt_reg != PWM_LAST)
        pwm_cnt_next = pwm_cnt_reg + {{(PWM_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign tick = enable && (decay_cnt_reg == DECAY_PERIOD);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      led_q_reg     <= '0;
      decay_cnt_reg <= '0;
      pwm_cnt_reg   <= '0;
    end else begin
      led_q_reg     <= led_in;
      decay_cnt_reg <= decay_cnt_next;
      pwm_cnt_reg   <= pwm_cnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_led
      logic [PWM_BITS-1:0] level_reg, level_next;
      logic                pwm_reg;

      // Load beats decay, so a held-lit LED never fades.
      always_comb begin
        level_next = level_reg;
        if (!enable)
          level_next = '0;
        else if (led_q_reg[gi])
          level_next = max_level;
        else if (tick)
          level_next = level_reg >> DECAY_SHIFT;
      end

      always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
          level_reg <= '0;
          pwm_reg   <= 1'b0;
        end else begin
          level_reg <= level_next;
          pwm_reg   <= enable && (level_reg > pwm_cnt_reg);
        end
      end

      assign pwm_out[gi] = pwm_reg;
    end
  endgenerate

endmodule
